// File: rtl/counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg
// Shared types and constants for the up/down modulo counter family. This
// package is also imported by the existing counter bench.
//   cnt_mode_e : CNT_WRAP (0) wraps at range ends, CNT_SAT (1) saturates.
//   DIR_DOWN / DIR_UP : encodings of the dir input.
// ---------------------------------------------------------------------------
package counter_pkg;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

endpackage : counter_pkg

// File: rtl/updown_mod_counter.sv
// ---------------------------------------------------------------------------
// updown_mod_counter
// Up/down counter over the runtime range 0..max_value. It can wrap or
// saturate at either end. Overflow and underflow are reported as registered
// one-cycle pulses, as sticky flags, and through a saturating event counter.
// With WIDTH=8, max_value=255, dir=1 and mode=CNT_WRAP it behaves like the
// older 8-bit load/enable counter.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   enable       step the count this cycle
//   load         load min(load_value, max_value); has priority over enable
//   load_value   value to load
//   dir          1 = up, 0 = down
//   mode         CNT_WRAP / CNT_SAT
//   max_value    terminal count
//   clr_sticky   clear sticky flags and event counter (a new event wins)
//   count        registered count
//   overflow     1-cycle pulse: up-step attempted at the terminal count
//   underflow    1-cycle pulse: down-step attempted at 0
//   at_max       count >= max_value (combinational)
//   at_zero      count == 0 (combinational)
//   ovf_sticky   set by an overflow event
//   udf_sticky   set by an underflow event
//   evt_count    number of overflow+underflow events, saturating at all-ones
// ---------------------------------------------------------------------------
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               EVT_W       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dir,
  input  cnt_mode_e        mode,
  input  logic [WIDTH-1:0] max_value,
  input  logic             clr_sticky,
  output logic [WIDTH-1:0] count,
  output logic             overflow,
  output logic             underflow,
  output logic             at_max,
  output logic             at_zero,
  output logic             ovf_sticky,
  output logic             udf_sticky,
  output logic [EVT_W-1:0] evt_count
);

  logic [WIDTH-1:0] count_nxt;
  logic             ovf_evt;
  logic             udf_evt;
  logic             any_evt;
  logic [EVT_W-1:0] evt_count_nxt;

  assign at_max  = (count >= max_value);
  assign at_zero = (count == '0);
  assign any_evt = ovf_evt | udf_evt;

  // Next-state decode: load > enable > hold.
  always_comb begin
    // NOTE: every signal gets a default before any branch so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    count_nxt = count;
    ovf_evt   = 1'b0;
    udf_evt   = 1'b0;

    if (load) begin
      count_nxt = (load_value > max_value) ? max_value : load_value;
    end else if (enable) begin
      if (dir == DIR_UP) begin
        if (count < max_value) begin
          count_nxt = count + 1'b1;
        end else begin
          // Also covers count above a lowered max_value: an up-step there
          // is an overflow, and the count returns into range.
          ovf_evt   = 1'b1;
          count_nxt = (mode == CNT_WRAP) ? '0 : max_value;
        end
      end else begin
        if (count == '0) begin
          udf_evt   = 1'b1;
          count_nxt = (mode == CNT_WRAP) ? max_value : '0;
        end else begin
          // Above a lowered max_value the count walks down without a clamp.
          count_nxt = count - 1'b1;
        end
      end
    end
  end

  // Event counter: a clear restarts the count, and an event in the same
  // cycle is still counted.
  always_comb begin
    evt_count_nxt = evt_count;
    if (clr_sticky) begin
      evt_count_nxt = any_evt ? EVT_W'(1) : '0;
    end else if (any_evt && (evt_count != '1)) begin
      evt_count_nxt = evt_count + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples the values from before this edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= RESET_VALUE;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      ovf_sticky <= 1'b0;
      udf_sticky <= 1'b0;
      evt_count  <= '0;
    end else begin
      count      <= count_nxt;
      overflow   <= ovf_evt;
      underflow  <= udf_evt;
      ovf_sticky <= ovf_evt | (ovf_sticky & ~clr_sticky);
      udf_sticky <= udf_evt | (udf_sticky & ~clr_sticky);
      evt_count  <= evt_count_nxt;
    end
  end

endmodule : updown_mod_counter

// File: tb/tb_updown_mod_counter.sv
// ---------------------------------------------------------------------------
// tb_updown_mod_counter
// Directed bench for updown_mod_counter (WIDTH=8, EVT_W=4, RESET_VALUE=0).
// Inputs change 1 time unit after a rising edge. Outputs are checked at that
// same point, which is after the edge has settled.
// ---------------------------------------------------------------------------
module tb_updown_mod_counter;
  import counter_pkg::*;

  localparam int WIDTH = 8;
  localparam int EVT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             enable;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             dir;
  cnt_mode_e        mode;
  logic [WIDTH-1:0] max_value;
  logic             clr_sticky;
  logic [WIDTH-1:0] count;
  logic             overflow;
  logic             underflow;
  logic             at_max;
  logic             at_zero;
  logic             ovf_sticky;
  logic             udf_sticky;
  logic [EVT_W-1:0] evt_count;

  int vectors;
  int miscompares;

  updown_mod_counter #(
    .WIDTH      (WIDTH),
    .EVT_W      (EVT_W),
    .RESET_VALUE(8'd0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .load      (load),
    .load_value(load_value),
    .dir       (dir),
    .mode      (mode),
    .max_value (max_value),
    .clr_sticky(clr_sticky),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow),
    .at_max    (at_max),
    .at_zero   (at_zero),
    .ovf_sticky(ovf_sticky),
    .udf_sticky(udf_sticky),
    .evt_count (evt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    enable      = 1'b0;
    load        = 1'b0;
    load_value  = '0;
    dir         = DIR_UP;
    mode        = CNT_WRAP;
    max_value   = 8'd255;
    clr_sticky  = 1'b0;

    // ---- Reset state -------------------------------------------------------
    #2;
    check("rst_count", count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_udf", underflow, 0);
    check("rst_ovf_sticky", ovf_sticky, 0);
    check("rst_udf_sticky", udf_sticky, 0);
    check("rst_evt", evt_count, 0);
    check("rst_at_zero", at_zero, 1);
    step();
    rst_n = 1'b1;

    // ---- 1. Wrap up through 255 --------------------------------------------
    load = 1'b1; load_value = 8'd250; enable = 1'b1;
    step();
    check("t1_load", count, 250);
    load = 1'b0;
    repeat (5) step();
    check("t1_count255", count, 255);
    check("t1_ovf_before", overflow, 0);
    check("t1_at_max", at_max, 1);
    step();
    check("t1_wrap_count", count, 0);
    check("t1_wrap_ovf", overflow, 1);
    check("t1_wrap_sticky", ovf_sticky, 1);
    step();
    check("t1_after_count", count, 1);
    check("t1_after_ovf", overflow, 0);
    check("t1_evt", evt_count, 1);

    // ---- 2. Wrap down with max=9 -------------------------------------------
    max_value = 8'd9; load = 1'b1; load_value = 8'd2; dir = DIR_DOWN;
    step();
    check("t2_load", count, 2);
    load = 1'b0;
    step();
    check("t2_c1", count, 1);
    check("t2_c1_zero", at_zero, 0);
    step();
    check("t2_c0", count, 0);
    check("t2_c0_zero", at_zero, 1);
    check("t2_c0_udf", underflow, 0);
    step();
    check("t2_c9", count, 9);
    check("t2_c9_udf", underflow, 1);
    check("t2_c9_zero", at_zero, 0);
    check("t2_udf_sticky", udf_sticky, 1);
    step();
    check("t2_c8", count, 8);
    check("t2_c8_udf", underflow, 0);
    check("t2_evt", evt_count, 2);

    // Clear the flags so that section 3 starts from a known state.
    enable = 1'b0; clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    check("clr_evt", evt_count, 0);
    check("clr_ovf_sticky", ovf_sticky, 0);
    check("clr_udf_sticky", udf_sticky, 0);

    // ---- 3. Saturate -------------------------------------------------------
    mode = CNT_SAT; max_value = 8'd100; load = 1'b1; load_value = 8'd99;
    dir = DIR_UP;
    step();
    check("t3_load", count, 99);
    load = 1'b0; enable = 1'b1;
    step();
    check("t3_e1_count", count, 100);
    check("t3_e1_ovf", overflow, 0);
    step();
    check("t3_e2_count", count, 100);
    check("t3_e2_ovf", overflow, 1);
    step();
    check("t3_e3_count", count, 100);
    check("t3_e3_ovf", overflow, 1);
    check("t3_evt", evt_count, 2);
    load = 1'b1; load_value = 8'd0; dir = DIR_DOWN;
    step();
    check("t3_load0", count, 0);
    check("t3_load_no_ovf", overflow, 0);
    load = 1'b0;
    step();
    check("t3_hold0", count, 0);
    check("t3_udf", underflow, 1);
    check("t3_evt3", evt_count, 3);

    // ---- 4. Load clip, priority, lowered max -------------------------------
    mode = CNT_WRAP; max_value = 8'd50; load = 1'b1; enable = 1'b1;
    load_value = 8'd200; dir = DIR_UP;
    step();
    check("t4_clip", count, 50);
    check("t4_clip_ovf", overflow, 0);
    load = 1'b0; enable = 1'b0; max_value = 8'd10;
    step();
    check("t4_hold", count, 50);
    check("t4_above_at_max", at_max, 1);
    enable = 1'b1;
    step();
    check("t4_up_wrap", count, 0);
    check("t4_up_ovf", overflow, 1);
    max_value = 8'd50; load = 1'b1; load_value = 8'd50;
    step();
    check("t4_reload", count, 50);
    load = 1'b0; max_value = 8'd10; dir = DIR_DOWN;
    step();
    check("t4_down_49", count, 49);
    check("t4_down_no_udf", underflow, 0);
    check("t4_down_no_ovf", overflow, 0);

    // ---- 5. Sticky flags and event counter ---------------------------------
    enable = 1'b0; clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    check("t5_clr_evt", evt_count, 0);
    max_value = 8'd0; dir = DIR_UP; enable = 1'b1;
    repeat (20) step();
    check("t5_evt_sat", evt_count, 15);
    check("t5_ovf_cont", overflow, 1);
    check("t5_count0", count, 0);
    clr_sticky = 1'b1;
    step();
    check("t5_clr_evt_sticky", ovf_sticky, 1);
    check("t5_clr_evt_cnt", evt_count, 1);
    enable = 1'b0;
    step();
    clr_sticky = 1'b0;
    check("t5_clr_only_sticky", ovf_sticky, 0);
    check("t5_clr_only_cnt", evt_count, 0);
    check("t5_clr_only_ovf", overflow, 0);

    // ---- 6. Async reset mid-count ------------------------------------------
    load = 1'b1; load_value = 8'd0; max_value = 8'd0;
    step();
    load = 1'b0; enable = 1'b1;
    repeat (3) step();
    check("t6_pre_ovf", overflow, 1);
    check("t6_pre_evt", evt_count, 3);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_rst_count", count, 0);
    check("t6_rst_ovf", overflow, 0);
    check("t6_rst_sticky", ovf_sticky, 0);
    check("t6_rst_evt", evt_count, 0);
    enable = 1'b0;
    #1;
    rst_n = 1'b1;
    step();
    check("t6_post_ovf", overflow, 0);
    check("t6_post_evt", evt_count, 0);
    enable = 1'b1;
    step();
    check("t6_step_ovf", overflow, 1);
    check("t6_step_evt", evt_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_updown_mod_counter
